// File: rtl/goertzel_bank_tdm.sv
// rtl/goertzel_bank_tdm.sv - time-multiplexed Goertzel filter bank with one shared coefficient multiplier
module goertzel_bank_tdm #(
    parameter int NF = 11,
    parameter int NS = 1000,
    parameter int DW = 8,
    parameter int CW = 18,
    parameter int SW = 32,
    parameter int AW = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coef_wr,
    input  logic [AW-1:0]       coef_addr,
    input  logic [CW-1:0]       coef_data,
    input  logic                start,
    input  logic                cont_mode,
    output logic                busy,
    input  logic                smp_valid,
    input  logic [DW-1:0]       smp_data,
    output logic                smp_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [AW-1:0]       res_bin,
    output logic [2*SW-1:0]     res_power,
    output logic                ovf
);
    localparam int FB = CW - 3;
    localparam int KW = (NF > 1) ? $clog2(NF) : 1;
    localparam int MW = CW + SW;
    localparam int XW = MW + 2;
    localparam int PW = MW + SW + 2;
    localparam logic [KW-1:0] K_LAST   = KW'(NF - 1);
    localparam logic [15:0]   CNT_LAST = 16'(NS - 1);
    localparam logic signed [XW-1:0] S_MAX = {{(XW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [XW-1:0] S_MIN = {{(XW-SW+1){1'b1}}, {(SW-1){1'b0}}};
    localparam logic signed [PW-1:0] P_MAX = {{(PW-2*SW){1'b0}}, {(2*SW){1'b1}}};

    typedef enum logic [1:0] {IDLE, ACC, ITER, FIN} state_t;
    state_t state, state_nx;

    logic signed [SW-1:0] s1 [NF];
    logic signed [SW-1:0] s2 [NF];
    logic signed [CW-1:0] coef [NF];
    logic [KW-1:0]        k;
    logic [15:0]          smp_cnt;
    logic signed [DW-1:0] x;

    // FIN pipeline stage: operands fetched for one bin, awaiting the power computation
    logic                 a_valid;
    logic [AW-1:0]        a_bin;
    logic signed [SW-1:0] a_s1, a_s2;
    logic signed [MW-1:0] a_p;
    logic                 issued_all;

    logic signed [MW-1:0] mult, p;
    logic signed [XW-1:0] s0_full;
    logic signed [SW-1:0] s0_sat;
    logic                 s0_clip;
    logic signed [PW-1:0] pw_full;
    logic [2*SW-1:0]      pw_sat;
    logic                 advance, last_xfer;

    // shared multiplier: coef*s1 of bin k, used by both ITER and FIN fetch
    assign mult    = MW'(coef[k]) * MW'(s1[k]);
    assign p       = mult >>> FB;
    assign s0_full = XW'(x) + XW'(p) - XW'(s2[k]);
    assign s0_clip = (s0_full > S_MAX) || (s0_full < S_MIN);
    assign s0_sat  = (s0_full > S_MAX) ? S_MAX[SW-1:0] :
                     (s0_full < S_MIN) ? S_MIN[SW-1:0] : s0_full[SW-1:0];

    assign pw_full = PW'(a_s1) * PW'(a_s1) + PW'(a_s2) * PW'(a_s2) - PW'(a_p) * PW'(a_s2);
    assign pw_sat  = pw_full[PW-1] ? '0 : (pw_full > P_MAX) ? '1 : pw_full[2*SW-1:0];

    assign advance   = !res_valid || res_ready;
    assign last_xfer = res_valid && res_ready && (res_bin == AW'(NF - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state and status outputs
    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        smp_ready = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ACC;
            end
            ACC: begin
                smp_ready = 1'b1;
                if (smp_valid) state_nx = ITER;
            end
            ITER: if (k == K_LAST) state_nx = (smp_cnt == CNT_LAST) ? FIN : ACC;
            FIN:  if (last_xfer)   state_nx = cont_mode ? ACC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // per-bin state, coefficients, counters and result pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NF; i++) begin
                s1[i]   <= '0;
                s2[i]   <= '0;
                coef[i] <= '0;
            end
            k          <= '0;
            smp_cnt    <= '0;
            x          <= '0;
            ovf        <= 1'b0;
            a_valid    <= 1'b0;
            a_bin      <= '0;
            a_s1       <= '0;
            a_s2       <= '0;
            a_p        <= '0;
            issued_all <= 1'b0;
            res_valid  <= 1'b0;
            res_bin    <= '0;
            res_power  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_wr && (int'(coef_addr) < NF))
                        coef[coef_addr[KW-1:0]] <= coef_data;
                    if (start) begin
                        for (int i = 0; i < NF; i++) begin
                            s1[i] <= '0;
                            s2[i] <= '0;
                        end
                        ovf     <= 1'b0;
                        smp_cnt <= '0;
                        k       <= '0;
                    end
                end
                ACC: begin
                    if (smp_valid) begin
                        x <= smp_data;
                        k <= '0;
                    end
                end
                ITER: begin
                    s2[k] <= s1[k];
                    s1[k] <= s0_sat;
                    if (s0_clip) ovf <= 1'b1;
                    if (k == K_LAST) begin
                        k       <= '0;
                        smp_cnt <= smp_cnt + 16'd1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FIN: begin
                    if (advance) begin
                        res_valid <= a_valid;
                        if (a_valid) begin
                            res_bin   <= a_bin;
                            res_power <= pw_sat;
                        end
                        if (!issued_all) begin
                            a_valid <= 1'b1;
                            a_bin   <= AW'(k);
                            a_s1    <= s1[k];
                            a_s2    <= s2[k];
                            a_p     <= p;
                            if (k == K_LAST) issued_all <= 1'b1;
                            else             k <= k + 1'b1;
                        end else begin
                            a_valid <= 1'b0;
                        end
                    end
                    if (last_xfer) begin
                        issued_all <= 1'b0;
                        a_valid    <= 1'b0;
                        k          <= '0;
                        if (cont_mode) begin
                            for (int i = 0; i < NF; i++) begin
                                s1[i] <= '0;
                                s2[i] <= '0;
                            end
                            smp_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_goertzel_bank_tdm.sv
// tb/tb_goertzel_bank_tdm.sv - directed self-checking bench for goertzel_bank_tdm
module tb_goertzel_bank_tdm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // main instance: NF=2, NS=4
    logic        m_coef_wr = 0;
    logic [1:0]  m_coef_addr = 0;
    logic [17:0] m_coef_data = 0;
    logic        m_start = 0, m_cont = 0, m_busy;
    logic        m_smp_valid = 0, m_smp_ready;
    logic [7:0]  m_smp_data = 0;
    logic        m_res_valid, m_res_ready = 0;
    logic [1:0]  m_res_bin;
    logic [63:0] m_res_power;
    logic        m_ovf;

    // saturation / throughput instance: NF=11, NS=30, SW=16
    logic        s_coef_wr = 0;
    logic [3:0]  s_coef_addr = 0;
    logic [17:0] s_coef_data = 0;
    logic        s_start = 0, s_cont = 0, s_busy;
    logic        s_smp_valid = 0, s_smp_ready;
    logic [7:0]  s_smp_data = 0;
    logic        s_res_valid, s_res_ready = 0;
    logic [3:0]  s_res_bin;
    logic [31:0] s_res_power;
    logic        s_ovf;

    goertzel_bank_tdm #(.NF(2), .NS(4), .DW(8), .CW(18), .SW(32), .AW(2)) u_main (
        .clk(clk), .rst(rst), .coef_wr(m_coef_wr), .coef_addr(m_coef_addr), .coef_data(m_coef_data),
        .start(m_start), .cont_mode(m_cont), .busy(m_busy), .smp_valid(m_smp_valid),
        .smp_data(m_smp_data), .smp_ready(m_smp_ready), .res_valid(m_res_valid),
        .res_ready(m_res_ready), .res_bin(m_res_bin), .res_power(m_res_power), .ovf(m_ovf)
    );

    goertzel_bank_tdm #(.NF(11), .NS(30), .DW(8), .CW(18), .SW(16), .AW(4)) u_sat (
        .clk(clk), .rst(rst), .coef_wr(s_coef_wr), .coef_addr(s_coef_addr), .coef_data(s_coef_data),
        .start(s_start), .cont_mode(s_cont), .busy(s_busy), .smp_valid(s_smp_valid),
        .smp_data(s_smp_data), .smp_ready(s_smp_ready), .res_valid(s_res_valid),
        .res_ready(s_res_ready), .res_bin(s_res_bin), .res_power(s_res_power), .ovf(s_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_send(input logic [7:0] d);
        int n = 0;
        m_smp_valid = 1'b1;
        m_smp_data  = d;
        while (!m_smp_ready && n < 100) begin
            tick();
            n++;
        end
        chk("m_send_ready", m_smp_ready, 1);
        tick();
        m_smp_valid = 1'b0;
    endtask

    task automatic m_wait_valid(output int n);
        n = 0;
        while (!m_res_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic m_chk_reset(input string tag);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_smp_ready"}, m_smp_ready, 0);
        chk({tag, "_res_valid"}, m_res_valid, 0);
        chk({tag, "_res_bin"}, m_res_bin, 0);
        chk({tag, "_res_power"}, m_res_power, 0);
        chk({tag, "_ovf"}, m_ovf, 0);
    endtask

    initial begin
        int n, acc, first, second, cyc;

        tick();
        tick();
        rst = 1'b0;
        m_chk_reset("reset");

        // coef[0]=2.0, then an out-of-range write that would alias onto bin 0
        m_coef_wr = 1; m_coef_addr = 2'd0; m_coef_data = 18'd65536;
        tick();
        m_coef_addr = 2'd2; m_coef_data = 18'd0;
        tick();
        m_coef_wr = 0;

        m_start = 1;
        tick();
        m_start = 0;
        chk("acc_busy", m_busy, 1);
        chk("acc_smp_ready", m_smp_ready, 1);

        // write to bin 1 during ACC must be dropped
        m_coef_wr = 1; m_coef_addr = 2'd1; m_coef_data = 18'd65536;
        tick();
        m_coef_wr = 0;

        m_send(8'd1);
        chk("ready_low_after_accept", m_smp_ready, 0);
        n = 0;
        while (!m_smp_ready && n < 100) begin tick(); n++; end
        chk("ready_back_after_nf", n, 2);
        m_start = 1;
        tick();
        m_start = 0;
        m_send(8'd1);
        m_send(8'd1);
        m_send(8'd1);
        m_wait_valid(n);
        chk("fin_latency", n, 4);

        // backpressure on bin 0
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", m_res_valid, 1);
            chk("bp_bin", m_res_bin, 0);
            chk("bp_power", m_res_power, 16);
            tick();
        end
        m_res_ready = 1;
        tick();
        chk("bin1_valid", m_res_valid, 1);
        chk("bin1_bin", m_res_bin, 1);
        chk("bin1_power", m_res_power, 0);
        tick();
        m_res_ready = 0;
        chk("done_busy", m_busy, 0);
        chk("done_valid", m_res_valid, 0);

        // continuous mode: two back-to-back blocks
        m_cont = 1;
        m_res_ready = 1;
        m_start = 1;
        tick();
        m_start = 0;
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 4; s++) m_send(8'd1);
            m_wait_valid(n);
            chk("cont_valid", m_res_valid, 1);
            chk("cont_bin0", m_res_bin, 0);
            chk("cont_power0", m_res_power, 16);
            tick();
            chk("cont_bin1", m_res_bin, 1);
            chk("cont_power1", m_res_power, 0);
            tick();
            chk("cont_busy", m_busy, 1);
            chk("cont_smp_ready", m_smp_ready, 1);
            chk("cont_valid_low", m_res_valid, 0);
        end
        m_cont = 0;
        m_res_ready = 0;

        // reset mid-ITER
        m_send(8'd1);
        rst = 1'b1;
        tick();
        m_chk_reset("mid_rst");
        tick();
        rst = 1'b0;
        tick();

        // saturation and throughput on the NF=11, SW=16 instance
        s_coef_wr = 1; s_coef_addr = 4'd0; s_coef_data = 18'd65536;
        tick();
        s_coef_wr = 0;
        s_start = 1;
        tick();
        s_start = 0;
        s_smp_valid = 1; s_smp_data = 8'd127;
        acc = 0; first = -1; second = -1; cyc = 0;
        while (!s_res_valid && cyc < 2000) begin
            if (s_smp_ready) begin
                if (acc == 0) first = cyc;
                else if (acc == 1) second = cyc;
                acc++;
            end
            tick();
            cyc++;
        end
        s_smp_valid = 0;
        chk("tput_gap", second - first, 12);
        chk("tput_accepts", acc, 30);
        chk("sat_res_valid", s_res_valid, 1);
        chk("sat_ovf", s_ovf, 1);
        s_res_ready = 1;
        for (int i = 0; i < 11; i++) begin
            chk("sat_bin", s_res_bin, i);
            chk("sat_power", s_res_power, (i == 0) ? 0 : 32258);
            tick();
        end
        s_res_ready = 0;
        chk("sat_idle", s_busy, 0);
        chk("sat_ovf_held", s_ovf, 1);
        s_start = 1;
        tick();
        s_start = 0;
        chk("ovf_cleared", s_ovf, 0);
        chk("sat_restart_busy", s_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
